clk_div_bank: RTL and testbench
===============================

CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent divider channels (1..16).
REQ-002 Parameter CNT_W, default 25, width of each channel counter and divisor.
REQ-003 Parameter DEFAULT_DIV, default 13500000, divisor loaded into every channel at reset.
REQ-004 clk_in  input  1  system clock; all logic on rising edge.
REQ-005 reset_in  input  1  asynchronous, active-low reset.
REQ-006 ch_en  input  NUM_CH  per-channel run enable.
REQ-007 wr_en  input  1  divisor/mode write strobe, one write per cycle.
REQ-008 wr_ch  input  clog2(NUM_CH) (min 1)  target channel of write.
REQ-009 wr_div  input  CNT_W  new divisor.
REQ-010 wr_mode  input  1  new mode: 0 = toggle (square wave), 1 = pulse (one-cycle tick).
REQ-011 clk_out  output  NUM_CH  registered divided clock per channel (toggle mode).
REQ-012 tick_out  output  NUM_CH  registered one-cycle tick per channel (pulse mode).
REQ-013 pending  output  NUM_CH  per-channel flag: shadow divisor/mode not yet applied.

Function
REQ-014 Each channel SHALL hold active div/mode registers and shadow div/mode registers plus a CNT_W counter.
REQ-015 Enabled channel counter SHALL count 0..div; terminal count is counter == div, after which counter SHALL return to 0.
REQ-016 Toggle mode: clk_out SHALL invert on each terminal count; period = 2*(div+1) clk_in cycles; tick_out held 0.
REQ-017 Pulse mode: tick_out SHALL be 1 for exactly the cycle following each terminal count; period = div+1 cycles; clk_out held 0.
REQ-018 div = 0 SHALL give clk_out = clk_in/2 (toggle) or tick_out continuously 1 (pulse).
REQ-019 Write (wr_en=1) SHALL load shadow of wr_ch and set pending[wr_ch] on the next edge; a later write before application overwrites shadow.
REQ-020 Shadow SHALL be copied to active, and pending cleared, on the channel's terminal count only (glitch-free retune); counter restarts at 0.
REQ-021 Write coinciding with terminal count of the same channel SHALL stay pending and apply at the following terminal count.
REQ-022 wr_ch >= NUM_CH SHALL be ignored (no state change).
REQ-023 Disabled channel: counter, clk_out, tick_out SHALL be 0 one cycle after ch_en falls; pending shadow SHALL apply immediately while disabled.
REQ-024 Re-enable SHALL restart counting from 0 with clk_out = 0.
REQ-025 Mode change SHALL clear clk_out and tick_out at the applying terminal count.

Reset
REQ-026 reset_in low SHALL asynchronously clear all counters, clk_out, tick_out, pending; active and shadow div = DEFAULT_DIV, mode = 0.
REQ-027 Reset assertion mid-period SHALL abort the period with no glitch beyond the asynchronous clear.

Configuration
REQ-028 Macro CLK_DIV_SYNC_EN defined SHALL add input sync_in (1 bit); sync_in = 1 SHALL on the next edge zero all counters, clk_out, tick_out and apply all pending shadows, with priority over terminal count.
REQ-029 Without CLK_DIV_SYNC_EN the port SHALL be absent and channels phase-independent.

Structure
REQ-030 Shared package SHALL hold mode encoding constants (MODE_TOGGLE, MODE_PULSE) and DEFAULT_DIV default.
REQ-031 Per-channel logic SHALL be sub-module clk_div_chan, instantiated NUM_CH times by generate; write decode stays in top.

Verification (NUM_CH=2, CNT_W=8, DEFAULT_DIV=3)
REQ-032 Release reset, ch_en=2'b11 -> clk_out[0] first rises 4 cycles after release, period 8, tick_out=0.
REQ-033 Mid-period write ch1 div=1 mode=1 -> pending[1]=1 until ch1 terminal count, then tick_out[1] every 2 cycles, clk_out[1]=0.
REQ-034 Write ch0 div=0 mode=0 -> after apply clk_out[0] toggles every cycle; write on a terminal-count cycle applies one period later.
REQ-035 Drop ch_en[0] mid-count -> clk_out[0]=0 next cycle; re-enable -> first toggle after 1 cycle (div=0).
REQ-036 Assert reset_in mid-period -> outputs 0 immediately, divisors back to 3; wr_ch=2 write ignored.
REQ-037 With CLK_DIV_SYNC_EN, sync_in pulse -> both counters 0, outputs 0, subsequent edges aligned across channels.

Source files
------------

// File: rtl/clk_div_bank_pkg.sv
// Shared definitions for the clock divider bank: output mode encoding and the
// power-on divisor.
package clk_div_bank_pkg;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } div_mode_e;

    localparam int unsigned DEFAULT_DIV_VAL = 13500000;

endpackage

// File: rtl/clk_div_bank_chan.sv
// One divider channel: active/shadow divisor and mode, counter, and
// registered square-wave or tick output. Retunes only at the terminal count.
module clk_div_chan
    import clk_div_bank_pkg::*;
#(
    parameter int unsigned      CNT_W   = 25,
    parameter logic [CNT_W-1:0] RST_DIV = '0
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic             wr_mode,
    output logic             clk_out,
    output logic             tick_out,
    output logic             pending
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act_div;
    logic [CNT_W-1:0] sh_div;
    div_mode_e        act_mode;
    div_mode_e        sh_mode;
    logic             tc;
    logic             apply_now;

    // A pending shadow is taken whenever the period is restarted anyway:
    // terminal count, channel disabled, or bank-wide sync.
    always_comb begin
        tc        = (cnt == act_div);
        apply_now = pending && (sync || !en || tc);
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            cnt      <= '0;
            act_div  <= RST_DIV;
            sh_div   <= RST_DIV;
            act_mode <= MODE_TOGGLE;
            sh_mode  <= MODE_TOGGLE;
            pending  <= 1'b0;
            clk_out  <= 1'b0;
            tick_out <= 1'b0;
        end else begin
            if (apply_now) begin
                act_div  <= sh_div;
                act_mode <= sh_mode;
            end

            if (wr) begin
                sh_div  <= wr_div;
                sh_mode <= div_mode_e'(wr_mode);
                pending <= 1'b1;
            end else if (apply_now) begin
                pending <= 1'b0;
            end

            if (sync || !en) begin
                cnt      <= '0;
                clk_out  <= 1'b0;
                tick_out <= 1'b0;
            end else if (tc) begin
                cnt <= '0;
                // A mode switch starts the new waveform from a low level.
                if (apply_now && (sh_mode != act_mode)) begin
                    clk_out  <= 1'b0;
                    tick_out <= 1'b0;
                end else if (act_mode == MODE_TOGGLE) begin
                    clk_out  <= ~clk_out;
                    tick_out <= 1'b0;
                end else begin
                    clk_out  <= 1'b0;
                    tick_out <= 1'b1;
                end
            end else begin
                cnt      <= cnt + CNT_W'(1);
                tick_out <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH programmable clock dividers with a shared write port.
// Define CLK_DIV_SYNC_EN to add sync_in for phase-aligning all channels.
module clk_div_bank
    import clk_div_bank_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 25,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_VAL,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              reset_in,
`ifdef CLK_DIV_SYNC_EN
    input  logic              sync_in,
`endif
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    input  logic              wr_mode,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick_out,
    output logic [NUM_CH-1:0] pending
);

    logic sync_all;

`ifdef CLK_DIV_SYNC_EN
    assign sync_all = sync_in;
`else
    assign sync_all = 1'b0;
`endif

    // Out-of-range channel numbers match no channel and are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        logic wr_hit;
        assign wr_hit = wr_en && (wr_ch == CH_W'(i));

        clk_div_chan #(
            .CNT_W   (CNT_W),
            .RST_DIV (CNT_W'(DEFAULT_DIV))
        ) u_chan (
            .clk_in   (clk_in),
            .reset_in (reset_in),
            .en       (ch_en[i]),
            .sync     (sync_all),
            .wr       (wr_hit),
            .wr_div   (wr_div),
            .wr_mode  (wr_mode),
            .clk_out  (clk_out[i]),
            .tick_out (tick_out[i]),
            .pending  (pending[i])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Randomized bench for clk_div_bank (NUM_CH=2, CNT_W=8, DEFAULT_DIV=3) against a
// cycle-count model, plus directed literal checks.
module tb_clk_div_bank;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;
    localparam int DEF    = 3;

    logic              clk_in = 1'b0;
    logic              reset_in;
    logic              sync_in;
    logic [NUM_CH-1:0] ch_en;
    logic              wr_en;
    logic [0:0]        wr_ch;
    logic [CNT_W-1:0]  wr_div;
    logic              wr_mode;
    logic [NUM_CH-1:0] clk_out, tick_out, pending;

    logic [2:0] ch_en3;
    logic       w3_en;
    logic [1:0] w3_ch;
    logic [2:0] clk3, tick3, pend3;

    int n_cmp = 0;
    int n_bad = 0;

    int m_act_div [NUM_CH];
    int m_sh_div  [NUM_CH];
    int m_start   [NUM_CH];
    bit m_act_mode[NUM_CH];
    bit m_sh_mode [NUM_CH];
    bit m_pend    [NUM_CH];
    bit m_clk     [NUM_CH];
    bit m_tick    [NUM_CH];
    int cyc = 0;

    always #5 clk_in = ~clk_in;

    clk_div_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) u_dut (
        .clk_in   (clk_in),
        .reset_in (reset_in),
`ifdef CLK_DIV_SYNC_EN
        .sync_in  (sync_in),
`endif
        .ch_en    (ch_en),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_div   (wr_div),
        .wr_mode  (wr_mode),
        .clk_out  (clk_out),
        .tick_out (tick_out),
        .pending  (pending)
    );

    // Three-channel instance so an out-of-range channel number is representable.
    clk_div_bank #(.NUM_CH(3), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) u_dut3 (
        .clk_in   (clk_in),
        .reset_in (reset_in),
`ifdef CLK_DIV_SYNC_EN
        .sync_in  (1'b0),
`endif
        .ch_en    (ch_en3),
        .wr_en    (w3_en),
        .wr_ch    (w3_ch),
        .wr_div   (wr_div),
        .wr_mode  (wr_mode),
        .clk_out  (clk3),
        .tick_out (tick3),
        .pending  (pend3)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_act_div[c]  = DEF;
            m_sh_div[c]   = DEF;
            m_act_mode[c] = 1'b0;
            m_sh_mode[c]  = 1'b0;
            m_pend[c]     = 1'b0;
            m_clk[c]      = 1'b0;
            m_tick[c]     = 1'b0;
            m_start[c]    = cyc;
        end
    endtask

    // A running channel's period starts at m_start; its terminal count is the
    // last cycle of each (div+1)-cycle window measured from there.
    task automatic model_step();
        if (!reset_in) begin
            cyc++;
            model_reset();
            return;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            bit en, hit, tc, apply;
            int d;
            en    = ch_en[c];
            hit   = wr_en && (int'(wr_ch) == c);
            d     = m_act_div[c];
            tc    = ((cyc - m_start[c]) % (d + 1)) == d;
            apply = m_pend[c] && (sync_in || !en || tc);
            if (!en || sync_in) begin
                m_clk[c]   = 1'b0;
                m_tick[c]  = 1'b0;
                m_start[c] = cyc + 1;
            end else if (tc) begin
                m_start[c] = cyc + 1;
                if (apply && (m_sh_mode[c] != m_act_mode[c])) begin
                    m_clk[c]  = 1'b0;
                    m_tick[c] = 1'b0;
                end else if (!m_act_mode[c]) begin
                    m_clk[c]  = !m_clk[c];
                    m_tick[c] = 1'b0;
                end else begin
                    m_tick[c] = 1'b1;
                end
            end else begin
                m_tick[c] = 1'b0;
            end
            if (apply) begin
                m_act_div[c]  = m_sh_div[c];
                m_act_mode[c] = m_sh_mode[c];
            end
            if (hit) begin
                m_sh_div[c]  = int'(wr_div);
                m_sh_mode[c] = wr_mode;
                m_pend[c]    = 1'b1;
            end else if (apply) begin
                m_pend[c] = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_in);
            model_step();
            #1;
        end
    endtask

    always @(negedge clk_in) begin
        logic [NUM_CH-1:0] ec, et, ep;
        for (int c = 0; c < NUM_CH; c++) begin
            ec[c] = m_clk[c];
            et[c] = m_tick[c];
            ep[c] = m_pend[c];
        end
        checkOutput("model_clk_out", clk_out, ec);
        checkOutput("model_tick_out", tick_out, et);
        checkOutput("model_pending", pending, ep);
    end

    initial begin
        reset_in = 1'b0;
        sync_in  = 1'b0;
        ch_en    = '0;
        wr_en    = 1'b0;
        wr_ch    = '0;
        wr_div   = '0;
        wr_mode  = 1'b0;
        ch_en3   = '0;
        w3_en    = 1'b0;
        w3_ch    = '0;
        model_reset();

        applyStimulus(2);
        checkOutput("reset_outputs", {clk_out, tick_out, pending}, 0);

        // Release with both channels running at the reset divisor of 3.
        reset_in = 1'b1;
        ch_en    = 2'b11;
        applyStimulus(3);
        checkOutput("first_rise_before", clk_out, 2'b00);
        applyStimulus(1);
        checkOutput("first_rise", clk_out, 2'b11);
        checkOutput("toggle_no_tick", tick_out, 2'b00);
        applyStimulus(4);
        checkOutput("period8_fall", clk_out, 2'b00);

        // Mid-period retune of channel 1 to pulse mode, div 1.
        applyStimulus(1);
        wr_en = 1'b1; wr_ch = 1'b1; wr_div = 8'd1; wr_mode = 1'b1;
        applyStimulus(1);
        wr_en = 1'b0;
        checkOutput("ch1_pending_set", pending, 2'b10);
        applyStimulus(1);
        checkOutput("ch1_pending_hold", pending, 2'b10);
        applyStimulus(1);
        checkOutput("ch1_applied", pending, 2'b00);
        checkOutput("ch1_mode_clear", clk_out, 2'b01);
        applyStimulus(1);
        checkOutput("ch1_tick_lo", tick_out, 2'b00);
        applyStimulus(1);
        checkOutput("ch1_tick_hi", tick_out, 2'b10);
        applyStimulus(1);
        checkOutput("ch1_tick_lo2", tick_out, 2'b00);
        applyStimulus(1);
        checkOutput("ch1_tick_hi2", tick_out, 2'b10);

        // Channel 0 to div 0 mid-period, then a write landing on a terminal count.
        applyStimulus(1);
        wr_en = 1'b1; wr_ch = 1'b0; wr_div = 8'd0; wr_mode = 1'b0;
        applyStimulus(1);
        wr_en = 1'b0;
        checkOutput("ch0_pending_set", pending, 2'b01);
        applyStimulus(2);
        checkOutput("ch0_applied", pending, 2'b00);
        checkOutput("ch0_apply_toggle", clk_out[0], 1'b1);
        applyStimulus(1);
        checkOutput("ch0_div0_a", clk_out[0], 1'b0);
        applyStimulus(1);
        checkOutput("ch0_div0_b", clk_out[0], 1'b1);
        wr_en = 1'b1; wr_ch = 1'b0; wr_div = 8'd2; wr_mode = 1'b0;
        applyStimulus(1);
        wr_en = 1'b0;
        checkOutput("tc_write_pending", pending[0], 1'b1);
        checkOutput("tc_write_clk", clk_out[0], 1'b0);
        applyStimulus(1);
        checkOutput("tc_write_applied", pending[0], 1'b0);
        checkOutput("tc_write_clk2", clk_out[0], 1'b1);
        applyStimulus(2);
        checkOutput("div2_hold", clk_out[0], 1'b1);
        applyStimulus(1);
        checkOutput("div2_toggle", clk_out[0], 1'b0);

        // Disable channel 0, retune while idle, re-enable.
        ch_en = 2'b10;
        applyStimulus(1);
        checkOutput("disable_clk", clk_out[0], 1'b0);
        wr_en = 1'b1; wr_ch = 1'b0; wr_div = 8'd0; wr_mode = 1'b0;
        applyStimulus(1);
        wr_en = 1'b0;
        checkOutput("idle_pending", pending[0], 1'b1);
        applyStimulus(1);
        checkOutput("idle_apply", pending[0], 1'b0);
        ch_en = 2'b11;
        applyStimulus(1);
        checkOutput("reenable_first", clk_out[0], 1'b1);
        applyStimulus(1);
        checkOutput("reenable_second", clk_out[0], 1'b0);

        // Asynchronous reset mid-period restores the default divisor.
        applyStimulus(2);
        reset_in = 1'b0;
        #1;
        checkOutput("async_clear", {clk_out, tick_out, pending}, 0);
        model_reset();
        applyStimulus(2);
        reset_in = 1'b1;
        w3_en = 1'b1; w3_ch = 2'd3; wr_div = 8'd5;
        applyStimulus(1);
        checkOutput("bad_ch_ignored", pend3, 3'b000);
        w3_ch = 2'd2;
        applyStimulus(1);
        w3_en = 1'b0;
        checkOutput("good_ch_taken", pend3, 3'b100);
        checkOutput("rst_div_lo", clk_out, 2'b00);
        applyStimulus(1);
        checkOutput("rst_div_lo2", clk_out, 2'b00);
        applyStimulus(1);
        checkOutput("rst_div_rise", clk_out, 2'b11);
        checkOutput("rst_mode_toggle", tick_out, 2'b00);

`ifdef CLK_DIV_SYNC_EN
        ch_en = 2'b01;
        applyStimulus(2);
        ch_en = 2'b11;
        applyStimulus(1);
        sync_in = 1'b1;
        applyStimulus(1);
        sync_in = 1'b0;
        checkOutput("sync_clear", {clk_out, tick_out}, 0);
        applyStimulus(3);
        checkOutput("sync_aligned_lo", clk_out, 2'b00);
        applyStimulus(1);
        checkOutput("sync_aligned_hi", clk_out, 2'b11);
`endif

        for (int i = 0; i < 3000; i++) begin
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_ch   = 1'($urandom_range(0, 1));
            wr_div  = 8'($urandom_range(0, 5));
            wr_mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) begin
                int idx;
                idx = int'($urandom_range(0, 1));
                ch_en[idx] = ~ch_en[idx];
            end
`ifdef CLK_DIV_SYNC_EN
            sync_in = ($urandom_range(0, 39) == 0);
`endif
            if ($urandom_range(0, 499) == 0) begin
                reset_in = 1'b0;
                #1;
                checkOutput("rand_async_clear", {clk_out, tick_out, pending}, 0);
                model_reset();
                applyStimulus(1);
                reset_in = 1'b1;
            end
            applyStimulus(1);
        end

        wr_en = 1'b0;
        applyStimulus(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
